// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes.
// Used by the operand fetch stage and its scoreboard.
package regfile_pkg;

  localparam int DW           = 64;
  localparam int AW           = 5;
  localparam int NREG         = 2 ** AW;
  localparam int MAX_INFLIGHT = 8;

  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard with an inflight write counter.
// Ports: clk, rst, set_en/set_idx, clr_en/clr_idx in; busy, full, clr_hit out.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW           = regfile_pkg::AW,
  parameter int MAX_INFLIGHT = regfile_pkg::MAX_INFLIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AW-1:0]     set_idx,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_idx,
  output logic [2**AW-1:0]  busy,
  output logic              full,
  output logic              clr_hit
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  logic [2**AW-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign busy = busy_q;
  assign full = (cnt_q == CMAX);

  always_comb begin
    // A writeback only counts when it retires a tracked write.
    clr_hit = clr_en && busy_q[clr_idx];
    busy_d  = busy_q;
    if (clr_hit)
      busy_d[clr_idx] = 1'b0;
    // Set after clear: same-index collision leaves the bit set.
    if (set_en)
      busy_d[set_idx] = 1'b1;
    cnt_d = cnt_q;
    if (set_en && !clr_hit && cnt_q != CMAX)
      cnt_d = cnt_q + 1'b1;
    else if (clr_hit && !set_en && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, forwards writeback, stalls on hazards.
// Ports: in_* handshake, rf*_addr/data bank, wb_* bypass, out_* registered bundle.
module operand_fetch
  import regfile_pkg::*;
#(
  parameter int DW           = regfile_pkg::DW,
  parameter int AW           = regfile_pkg::AW,
  parameter int MAX_INFLIGHT = regfile_pkg::MAX_INFLIGHT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_srcA,
  input  logic [AW-1:0] in_srcB,
  input  logic [AW-1:0] in_dst,
  input  logic          in_wen,
  output logic [AW-1:0] rfA_addr,
  output logic [AW-1:0] rfB_addr,
  input  logic [DW-1:0] rfA_data,
  input  logic [DW-1:0] rfB_data,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_opA,
  output logic [DW-1:0] out_opB,
  output logic [AW-1:0] out_dst,
  output logic          out_wen
);

  logic [2**AW-1:0] busy;
  logic             full;
  logic             clr_hit;

  logic          fwd_a, fwd_b, fwd_d;
  logic          hazard, accept;
  logic [DW-1:0] op_a, op_b;

  logic          valid_q, valid_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [AW-1:0] dst_q, dst_d;
  logic          wen_q, wen_d;

  assign rfA_addr = in_srcA;
  assign rfB_addr = in_srcB;

  always_comb begin
    fwd_a = wb_valid && (wb_addr == in_srcA);
    fwd_b = wb_valid && (wb_addr == in_srcB);
    fwd_d = wb_valid && (wb_addr == in_dst);
    op_a  = fwd_a ? wb_data : rfA_data;
    op_b  = fwd_b ? wb_data : rfB_data;
    // A full scoreboard still admits a write if a slot frees this cycle.
    hazard = in_valid && (
               (busy[in_srcA] && !fwd_a) ||
               (busy[in_srcB] && !fwd_b) ||
               (in_wen && busy[in_dst] && !fwd_d) ||
               (in_wen && full && !clr_hit));
    in_ready = !rst && !hazard && (!valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

  reg_scoreboard #(
    .AW           (AW),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept && in_wen),
    .set_idx (in_dst),
    .clr_en  (wb_valid),
    .clr_idx (wb_addr),
    .busy    (busy),
    .full    (full),
    .clr_hit (clr_hit)
  );

  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    dst_d   = dst_q;
    wen_d   = wen_q;
    if (accept) begin
      valid_d = 1'b1;
      opa_d   = op_a;
      opb_d   = op_b;
      dst_d   = in_dst;
      wen_d   = in_wen;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      dst_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      dst_q   <= dst_d;
      wen_q   <= wen_d;
    end
  end

  assign out_valid = valid_q;
  assign out_opA   = opa_q;
  assign out_opB   = opb_q;
  assign out_dst   = dst_q;
  assign out_wen   = wen_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: DW, 64, register data width.
REQ-002 Parameter: AW, 5, register address width (2**AW registers).
REQ-003 Parameter: MAX_INFLIGHT, 8, maximum registers simultaneously awaiting writeback.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 in_valid  in  1  upstream offers an instruction.
REQ-008 in_ready  out  1  block accepts the instruction this cycle.
REQ-009 in_srcA, in_srcB  in  AW  source register addresses.
REQ-010 in_dst  in  AW  destination register address.
REQ-011 in_wen  in  1  instruction writes in_dst.
REQ-012 rfA_addr, rfB_addr  out  AW  combinational read addresses to the register bank.
REQ-013 rfA_data, rfB_data  in  DW  combinational read data from the register bank.
REQ-014 wb_valid, wb_addr, wb_data  in  1/AW/DW  writeback presented to the register bank this cycle.
REQ-015 out_valid  out  1  operand bundle valid.
REQ-016 out_ready  in  1  downstream consumes the bundle.
REQ-017 out_opA, out_opB, out_dst, out_wen  out  DW/DW/AW/1  registered operand bundle.

Function
REQ-018 rfA_addr/rfB_addr SHALL equal in_srcA/in_srcB combinationally at all times.
REQ-019 Operand A SHALL be wb_data when wb_valid and wb_addr==in_srcA, else rfA_data; operand B likewise.
REQ-020 Scoreboard busy[2**AW] SHALL mark registers with an issued, not-yet-written-back write.
REQ-021 hazard = in_valid and (busy[srcA] and not fwdA, or busy[srcB] and not fwdB, or in_wen and busy[in_dst] and not (wb_valid and wb_addr==in_dst), or in_wen and inflight==MAX_INFLIGHT and no clear this cycle).
REQ-022 in_ready SHALL be (not hazard) and (not out_valid or out_ready), combinational.
REQ-023 Accept = in_valid and in_ready; on accept the bundle SHALL be registered and out_valid asserted next cycle (latency 1).
REQ-024 While out_valid and not out_ready, all out_* SHALL hold stable.
REQ-025 out_valid SHALL clear after a cycle with out_valid and out_ready and no accept; accept in the same cycle SHALL replace the bundle (full throughput).
REQ-026 Accept with in_wen SHALL set busy[in_dst] and increment inflight.
REQ-027 wb_valid with busy[wb_addr] SHALL clear it and decrement inflight; wb to a non-busy register SHALL change no scoreboard state.
REQ-028 Same-cycle set and clear of the same index SHALL leave busy set, inflight unchanged.
REQ-029 Same-cycle set and clear of different indices SHALL leave inflight unchanged.
REQ-030 inflight SHALL never exceed MAX_INFLIGHT nor wrap below 0.

Reset
REQ-031 While rst is high: out_valid=0, out_opA=out_opB=0, out_dst=0, out_wen=0, busy all 0, inflight=0, in_ready=0.
REQ-032 Reset mid-operation SHALL discard the held bundle and all scoreboard state; wb_valid during reset SHALL be ignored.
REQ-033 First accept SHALL be possible on the first cycle with rst low.

Structure
REQ-034 Shared package regfile_pkg SHALL hold DW, AW, NREG=2**AW, and typedefs reg_addr_t and reg_data_t.
REQ-035 Scoreboard and inflight counter SHALL be sub-module reg_scoreboard (set/clear ports, busy vector, full flag).

Verification
REQ-036 Reset, then srcA=3, srcB=4, bank r3=3, r4=4, out_ready=1 -> next cycle out_valid=1, opA=3, opB=4.
REQ-037 Issue dst=5 wen=1, then srcA=5 -> in_ready=0 until wb_valid addr=5 data=0xAB, same cycle accepted, opA=0xAB.
REQ-038 out_ready=0 for 3 cycles with bundle held -> out_* stable, in_ready=0; release -> next bundle on following cycle.
REQ-039 Issue 8 writes to r1..r8 with no writeback -> 9th wen instruction stalls; wb addr=1 -> accepted same cycle, inflight stays 8.
REQ-040 Accept dst=7 while wb_valid addr=7 (previously busy) -> busy[7]=1, inflight unchanged.
REQ-041 Assert rst with out_valid=1 and 3 registers busy -> next cycle out_valid=0, busy=0, srcA=any accepted on first post-reset cycle.
